vending_machine_n: RTL and testbench
====================================

# vending_machine_n

Parametrised N-item vending-machine controller. It accepts multi-value coins and holds a saturating credit. It vends a selected item when the credit and stock allow, tracks per-item stock, and returns change one unit per cycle on cancel or after a vend. It sits between the debounced panel inputs and the LED and dispense drivers; `o_credit` feeds the existing segment-decoder path.

## Interface
Parameters:
- `N_ITEM`, 4: number of products.
- `CREDIT_W`, 8: credit register width.
- `CREDIT_MAX`, 99: credit ceiling in money units; must be < 2^CREDIT_W.
- `PRICES`, {8'd12,8'd8,8'd5,8'd3}: packed N_ITEM×8. Item k price is `PRICES[8k+7:8k]` units, each 1..CREDIT_MAX.
- `STOCK_W`, 4: per-item stock counter width.
- `STOCK_INIT`, 3: stock loaded at reset and on refill.
- `DISP_CYC`, 4: cycles `o_vend` is held, ≥1.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `i_coin_valid`  in  1  — one-cycle coin-accepted strobe.
- `i_coin_units`  in  4  — coin value in units; 0 is treated as reject.
- `i_sel`  in  N_ITEM  — selection buttons, one-cycle pulses.
- `i_cancel`  in  1  — refund request pulse.
- `i_refill`  in  1  — reload all stock pulse.
- `o_credit`  out  CREDIT_W  — current credit, binary.
- `o_led`  out  N_ITEM  — bit k = item k affordable and in stock, in IDLE only.
- `o_soldout`  out  N_ITEM  — bit k = stock k is 0.
- `o_vend`  out  N_ITEM  — one-hot dispense strobe, DISP_CYC cycles.
- `o_change`  out  1  — one pulse per returned unit.
- `o_coin_reject`  out  1  — one-cycle pulse; the coin must be returned.
- `o_busy`  out  1  — state ≠ IDLE.

## Operation
- States:
  - IDLE: accepts coins, selection, cancel and refill.
  - VEND: `o_vend` active.
  - CHANGE: returns credit.
- IDLE, coin:
  - If credit + units ≤ CREDIT_MAX and units ≠ 0, credit += units.
  - Otherwise pulse `o_coin_reject` and leave credit unchanged.
  - Sum computed at CREDIT_W+1 bits; no wrap.
- IDLE, select: winner k = lowest set index of `i_sel`.
  - If credit ≥ price(k) and stock(k) > 0: credit −= price(k), stock(k) −= 1, go to VEND.
  - Otherwise ignore the selection; no state change.
- IDLE, cancel with credit > 0 goes to CHANGE. Cancel with credit = 0 is ignored.
- IDLE, refill loads all stock to STOCK_INIT. Refill outside IDLE is ignored.
- Same-cycle priority in IDLE is cancel > select > coin. A coin that loses priority is rejected (`o_coin_reject`).
- Coins in VEND or CHANGE are rejected. `i_sel`, `i_cancel` and `i_refill` outside IDLE are ignored.
- VEND: `o_vend[k]`=1 for exactly DISP_CYC cycles, timed by a down-counter. Then go to CHANGE if credit > 0, else IDLE.
- CHANGE: each cycle assert `o_change` and credit −= 1. When credit reaches 0, return to IDLE.
- `o_led` = 0 outside IDLE. `o_soldout` is valid in all states.
- Reset mid-operation returns to IDLE immediately: credit cleared, `o_vend`/`o_change` dropped, stock reloaded. Credit lost on reset is not refunded.

## Timing
- Reset values:
  - state IDLE.
  - `o_credit`=0.
  - stock = STOCK_INIT for all items.
  - `o_led` = items with price ≤ 0, which is none, so 0.
  - `o_soldout`=0 (or all-1 if STOCK_INIT=0).
  - `o_vend`=0, `o_change`=0, `o_coin_reject`=0, `o_busy`=0.
- All outputs are registered or decoded from registers only. There are no combinational input-to-output paths.
- Coin sampled at edge t: `o_credit` updates after t. `o_coin_reject` is high in the cycle after t, for one cycle.
- Select sampled at edge t:
  - State, `o_credit` and stock update after t.
  - `o_vend[k]` is high in cycles t+1..t+DISP_CYC.
  - The first `o_change` is in cycle t+DISP_CYC+1.
- Change of C units: exactly C consecutive `o_change` cycles, then `o_busy` falls the next cycle.
- `o_busy` rises in the cycle after an accepted select or cancel.

## Test plan
- Reset, then coins 2,1 → `o_credit` 2 then 3; `o_led`=4'b0001; `o_soldout`=0.
- Credit 3, `i_sel`=4'b0001 → `o_vend[0]` high 4 cycles, credit 0, no `o_change`, stock0=2, back to IDLE.
- Credit 10, `i_sel`=4'b0110 → item 1 chosen, credit 5. After `o_vend[1]` has been high 4 cycles, 5 `o_change` pulses follow, then `o_credit`=0.
- Credit 95 plus coin 5 → 95 kept and reject pulse. Coin 4 → 99. Coin during VEND → reject, credit unchanged.
- Three vends of item 0 (credit 9) → `o_soldout[0]`=1. A fourth select is ignored. `i_refill` → `o_soldout[0]`=0.
- Credit 7 with `i_cancel`+`i_sel`+`i_coin_valid` in the same cycle → 7 change pulses and coin rejected. `rst_n` low mid-CHANGE → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/vending_machine_n.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_n
// Purpose  : N-item vending controller: coin credit, stock tracking, change.
// Revision : 1.0
// ============================================================================
module vending_machine_n #(
    parameter int                  N_ITEM     = 4,
    parameter int                  CREDIT_W   = 8,
    parameter int                  CREDIT_MAX = 99,
    parameter logic [N_ITEM*8-1:0] PRICES     = {8'd12, 8'd8, 8'd5, 8'd3},
    parameter int                  STOCK_W    = 4,
    parameter int                  STOCK_INIT = 3,
    parameter int                  DISP_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_coin_valid,
    input  logic [3:0]          i_coin_units,
    input  logic [N_ITEM-1:0]   i_sel,
    input  logic                i_cancel,
    input  logic                i_refill,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [N_ITEM-1:0]   o_led,
    output logic [N_ITEM-1:0]   o_soldout,
    output logic [N_ITEM-1:0]   o_vend,
    output logic                o_change,
    output logic                o_coin_reject,
    output logic                o_busy
);

    localparam int                c_cmp_w      = (CREDIT_W > 8) ? CREDIT_W : 8;
    localparam int                c_cnt_w      = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    localparam logic [CREDIT_W:0] c_credit_max = (CREDIT_W + 1)'(CREDIT_MAX);
    localparam logic [c_cnt_w-1:0] c_disp_load = c_cnt_w'(DISP_CYC - 1);
    localparam logic [STOCK_W-1:0] c_stock_init = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [STOCK_W-1:0]    stock_q [N_ITEM];
    logic [STOCK_W-1:0]    stock_d [N_ITEM];
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic [N_ITEM-1:0]     vend_sel_q, vend_sel_d;
    logic                  reject_q, reject_d;

    logic [CREDIT_W:0]     w_sum;
    logic                  w_coin_ok;
    logic [c_cmp_w-1:0]    w_credit_ext;
    logic [N_ITEM-1:0]     w_win;
    logic                  w_found;
    logic [7:0]            w_price;
    logic                  w_stock_ok;
    logic                  w_sel_ok;

    // Extra carry bit keeps an oversize coin from wrapping past the ceiling.
    assign w_sum        = {1'b0, credit_q} + (CREDIT_W + 1)'(i_coin_units);
    assign w_coin_ok    = (i_coin_units != 4'd0) && (w_sum <= c_credit_max);
    assign w_credit_ext = c_cmp_w'(credit_q);

    always_comb begin
        w_win      = '0;
        w_found    = 1'b0;
        w_price    = '0;
        w_stock_ok = 1'b0;
        for (int k = 0; k < N_ITEM; k++) begin
            if (i_sel[k] && !w_found) begin
                w_found    = 1'b1;
                w_win[k]   = 1'b1;
                w_price    = PRICES[8*k +: 8];
                w_stock_ok = (stock_q[k] != '0);
            end
        end
    end

    assign w_sel_ok = w_found && w_stock_ok && (w_credit_ext >= c_cmp_w'(w_price));

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        stock_d    = stock_q;
        cnt_d      = cnt_q;
        vend_sel_d = vend_sel_q;
        reject_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_refill) begin
                    for (int k = 0; k < N_ITEM; k++) begin
                        stock_d[k] = c_stock_init;
                    end
                end
                if (i_cancel && (credit_q != '0)) begin
                    state_d  = S_CHANGE;
                    reject_d = i_coin_valid;
                end else if (w_sel_ok) begin
                    credit_d   = credit_q - CREDIT_W'(w_price);
                    vend_sel_d = w_win;
                    cnt_d      = c_disp_load;
                    state_d    = S_VEND;
                    reject_d   = i_coin_valid;
                    for (int k = 0; k < N_ITEM; k++) begin
                        if (w_win[k]) begin
                            stock_d[k] = stock_q[k] - STOCK_W'(1);
                        end
                    end
                end else if (i_coin_valid) begin
                    if (w_coin_ok) begin
                        credit_d = w_sum[CREDIT_W-1:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d = i_coin_valid;
                if (cnt_q == '0) begin
                    state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            S_CHANGE: begin
                reject_d = i_coin_valid;
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q == CREDIT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            cnt_q      <= '0;
            vend_sel_q <= '0;
            reject_q   <= 1'b0;
            for (int k = 0; k < N_ITEM; k++) begin
                stock_q[k] <= c_stock_init;
            end
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            vend_sel_q <= vend_sel_d;
            reject_q   <= reject_d;
            for (int k = 0; k < N_ITEM; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < N_ITEM; k++) begin : g_item
            assign o_soldout[k] = (stock_q[k] == '0);
            assign o_led[k]     = (state_q == S_IDLE) && (stock_q[k] != '0) &&
                                  (w_credit_ext >= c_cmp_w'(PRICES[8*k +: 8]));
        end
    endgenerate

    assign o_credit      = credit_q;
    assign o_vend        = (state_q == S_VEND) ? vend_sel_q : '0;
    assign o_change      = (state_q == S_CHANGE);
    assign o_coin_reject = reject_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_n
// Purpose  : Table-driven self-checking bench for vending_machine_n.
// Revision : 1.0
// ============================================================================
module tb_vending_machine_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_coin_valid;
    logic [3:0] i_coin_units;
    logic [3:0] i_sel;
    logic       i_cancel;
    logic       i_refill;
    logic [7:0] o_credit;
    logic [3:0] o_led;
    logic [3:0] o_soldout;
    logic [3:0] o_vend;
    logic       o_change;
    logic       o_coin_reject;
    logic       o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    vending_machine_n dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_coin_valid (i_coin_valid),
        .i_coin_units (i_coin_units),
        .i_sel        (i_sel),
        .i_cancel     (i_cancel),
        .i_refill     (i_refill),
        .o_credit     (o_credit),
        .o_led        (o_led),
        .o_soldout    (o_soldout),
        .o_vend       (o_vend),
        .o_change     (o_change),
        .o_coin_reject(o_coin_reject),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [3:0] units;
        logic [3:0] sel;
        logic       cancel;
        logic       refill;
        logic [7:0] credit;
        logic [3:0] led;
        logic [3:0] sold;
        logic [3:0] vend;
        logic       chg;
        logic       rej;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic cv, input logic [3:0] units, input logic [3:0] sel,
                       input logic cancel, input logic refill, input logic [7:0] credit,
                       input logic [3:0] led, input logic [3:0] sold, input logic [3:0] vend,
                       input logic chg, input logic rej, input logic busy);
        vec_t v;
        v.cv = cv; v.units = units; v.sel = sel; v.cancel = cancel; v.refill = refill;
        v.credit = credit; v.led = led; v.sold = sold; v.vend = vend;
        v.chg = chg; v.rej = rej; v.busy = busy;
        tbl.push_back(v);
    endtask

    function automatic logic [22:0] outs();
        return {o_credit, o_led, o_soldout, o_vend, o_change, o_coin_reject, o_busy};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (credit,led,sold,vend,chg,rej,busy)",
                      name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic clear_inputs();
        i_coin_valid = 1'b0; i_coin_units = '0; i_sel = '0; i_cancel = 1'b0; i_refill = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            i_coin_valid = tbl[i].cv;
            i_coin_units = tbl[i].units;
            i_sel        = tbl[i].sel;
            i_cancel     = tbl[i].cancel;
            i_refill     = tbl[i].refill;
            step();
            check($sformatf("row%0d", i), outs(),
                  {tbl[i].credit, tbl[i].led, tbl[i].sold, tbl[i].vend,
                   tbl[i].chg, tbl[i].rej, tbl[i].busy});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_a;
        int nchg;
        int nvend;
        bit done;

        // Coins 2,1 then vend item 0 with exact credit.
        add(1, 2, 0, 0, 0,   2, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   3, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 0, 0, 4'b0001, 0, 0, 1);
        repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Credit 10, two buttons: item 1 wins, 5 units of change follow.
        add(1, 5, 0, 0, 0,   5, 4'b0011, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0,  10, 4'b0111, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0110, 0, 0, 5, 0, 0, 4'b0010, 0, 0, 1);
        repeat (3) add(0, 0, 0, 0, 0, 5, 0, 0, 4'b0010, 0, 0, 1);
        for (int c = 5; c >= 1; c--) add(0, 0, 0, 0, 0, 8'(c), 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Build to 95, overflow coin rejected, fill to the 99 ceiling.
        for (int c = 15; c <= 90; c += 15) add(1, 15, 0, 0, 0, 8'(c), 4'hF, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0,  95, 4'hF, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0,  95, 4'hF, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0, 0,  99, 4'hF, 0, 0, 0, 0, 0);
        n_a = tbl.size();
        // Refill, then sell out item 0 with three exact-credit vends.
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 3; j++) begin
            add(1, 3, 0, 0, 0, 3, 4'b0001, 0, 0, 0, 0, 0);
            add(0, 0, 1, 0, 0, 0, 0, (j == 3) ? 4'b0001 : 4'b0000, 4'b0001, 0, 0, 1);
            repeat (3) add(0, 0, 0, 0, 0, 0, 0, (j == 3) ? 4'b0001 : 4'b0000, 4'b0001, 0, 0, 1);
            add(0, 0, 0, 0, 0, 0, 0, (j == 3) ? 4'b0001 : 4'b0000, 0, 0, 0, 0);
        end
        add(1, 3, 0, 0, 0,   3, 4'b0000, 4'b0001, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   3, 4'b0000, 4'b0001, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1,   3, 4'b0001, 4'b0000, 0, 0, 0, 0);
        // Cancel beats select and coin; the coin is rejected.
        add(1, 4, 0, 0, 0,   7, 4'b0011, 0, 0, 0, 0, 0);
        add(1, 5, 1, 1, 0,   7, 0, 0, 0, 1, 1, 1);
        for (int c = 6; c >= 4; c--) add(0, 0, 0, 0, 0, 8'(c), 0, 0, 0, 1, 0, 1);

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), 23'd0);
        rst_n = 1'b1;

        run_rows(0, n_a);

        // At the ceiling: vend item 3, coin during VEND, then 87 change pulses.
        i_sel = 4'b1000;
        step();
        check("vend3", outs(), {8'd87, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1});
        i_coin_valid = 1'b1; i_coin_units = 4'd3;
        step();
        check("coin_in_vend", outs(), {8'd87, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1});
        nchg = 0; nvend = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            if (o_change) nchg++;
            if (o_vend[3]) nvend++;
            if (!o_busy) done = 1'b1;
        end
        check_int("seq1_done", int'(done), 1);
        check_int("seq1_vend_rest", nvend, 2);
        check_int("seq1_change_pulses", nchg, 87);
        check_int("seq1_credit", int'(o_credit), 0);

        run_rows(n_a, tbl.size());

        // Asynchronous reset in the middle of CHANGE.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 23'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after_reset", outs(), 23'd0);
        i_coin_valid = 1'b1; i_coin_units = 4'd2;
        step();
        check("coin_after_reset", outs(), {8'd2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
